// File: rtl/top_fix_case2.sv
// Hard-decision parity checker for a small binary LDPC-style code.
// Loads an I x J parity-check matrix row by row, then A alpha probability
// columns. It derives a hard decision and a reliability per code bit, then
// walks the check rows one per cycle to build the syndrome and the minimum
// reliability of the bits participating in each row.
module top_fix_case2 #(
    parameter int J = 14,   // code length (columns of H)
    parameter int I = 7,    // check rows
    parameter int A = 2     // alphabet size (alpha beats per frame)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [J-1:0]     H_row,
    input  logic             H_row_tvalid,
    input  logic [J*8-1:0]   alpha_u_col,
    input  logic             alpha_u_col_tvalid,
    input  logic             alpha_u_col_tlast,
    output logic [J-1:0]     hard_dec,
    output logic [I-1:0]     syndrome,
    output logic             parity_ok,
    output logic [I*8-1:0]   row_min_rel,
    output logic             result_valid,
    output logic             busy
);

    localparam int RW = (I > 1) ? $clog2(I) : 1;
    localparam int AW = (A > 1) ? $clog2(A) : 1;

    localparam logic [2:0] S_IDLE       = 3'b000;
    localparam logic [2:0] S_LOAD_H     = 3'b001;
    localparam logic [2:0] S_LOAD_ALPHA = 3'b010;
    localparam logic [2:0] S_COMPUTE    = 3'b011;
    localparam logic [2:0] S_DONE       = 3'b100;

    // Kept under this exact name so it can be observed hierarchically.
    logic [2:0]     state;
    logic [RW-1:0]  r_row_cnt;   // H row being written, or check row being processed
    logic [AW-1:0]  r_beat_cnt;  // alpha column being written

    logic [J-1:0]   r_h     [I];
    logic [7:0]     r_alpha [A][J];

    logic [I-1:0]   r_syn_acc;
    logic [I*8-1:0] r_min_acc;

    logic [J-1:0]   w_hard;
    logic [7:0]     w_rel [J];
    logic [I-1:0]   w_syn_next;
    logic [I*8-1:0] w_min_next;

    // Frame sequencing: load H, load alpha, walk the rows, report.
    // NOTE: every sequential block uses non-blocking assignments so all
    // registers update together from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            r_row_cnt  <= '0;
            r_beat_cnt <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (H_row_tvalid) begin
                        r_row_cnt  <= RW'(1);
                        r_beat_cnt <= '0;
                        state      <= (I == 1) ? S_LOAD_ALPHA : S_LOAD_H;
                    end
                end
                S_LOAD_H: begin
                    if (H_row_tvalid) begin
                        if (r_row_cnt == RW'(I - 1)) begin
                            state <= S_LOAD_ALPHA;
                        end else begin
                            r_row_cnt <= r_row_cnt + RW'(1);
                        end
                    end
                end
                S_LOAD_ALPHA: begin
                    if (alpha_u_col_tvalid) begin
                        if (alpha_u_col_tlast || (r_beat_cnt == AW'(A - 1))) begin
                            state     <= S_COMPUTE;
                            r_row_cnt <= '0;
                        end else begin
                            r_beat_cnt <= r_beat_cnt + AW'(1);
                        end
                    end
                end
                S_COMPUTE: begin
                    if (r_row_cnt == RW'(I - 1)) begin
                        state <= S_DONE;
                    end else begin
                        r_row_cnt <= r_row_cnt + RW'(1);
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    // H and alpha storage; an early tlast zeroes the columns never sent.
    // NOTE: these arrays are reset explicitly because stale columns must
    // read as zero; that forces flops rather than a RAM macro here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < I; i++) begin
                r_h[i] <= '0;
            end
            for (int a = 0; a < A; a++) begin
                for (int j = 0; j < J; j++) begin
                    r_alpha[a][j] <= '0;
                end
            end
        end else begin
            if ((state == S_IDLE) && H_row_tvalid) begin
                r_h[0] <= H_row;
            end else if ((state == S_LOAD_H) && H_row_tvalid) begin
                r_h[r_row_cnt] <= H_row;
            end
            if ((state == S_LOAD_ALPHA) && alpha_u_col_tvalid) begin
                for (int a = 0; a < A; a++) begin
                    if (a == int'(r_beat_cnt)) begin
                        for (int j = 0; j < J; j++) begin
                            r_alpha[a][j] <= alpha_u_col[8*j +: 8];
                        end
                    end else if (alpha_u_col_tlast && (a > int'(r_beat_cnt))) begin
                        for (int j = 0; j < J; j++) begin
                            r_alpha[a][j] <= '0;
                        end
                    end
                end
            end
        end
    end

    // Per-bit argmax (lowest index wins ties) and margin to the runner-up.
    // NOTE: every combinational output gets a default first so no path
    // through the block leaves it unassigned and infers a latch.
    always_comb begin : p_decide
        logic [7:0]    v_best;
        logic [7:0]    v_second;
        logic [AW-1:0] v_idx;
        w_hard = '0;
        w_rel  = '{default: 8'h00};
        for (int j = 0; j < J; j++) begin
            v_best = r_alpha[0][j];
            v_idx  = '0;
            for (int a = 1; a < A; a++) begin
                if (r_alpha[a][j] > v_best) begin
                    v_best = r_alpha[a][j];
                    v_idx  = AW'(a);
                end
            end
            v_second = '0;
            for (int a = 0; a < A; a++) begin
                if ((AW'(a) != v_idx) && (r_alpha[a][j] > v_second)) begin
                    v_second = r_alpha[a][j];
                end
            end
            w_rel[j]  = v_best - v_second;
            w_hard[j] = v_idx[0];
        end
    end

    // Parity and minimum reliability for the row addressed by r_row_cnt,
    // merged into the accumulated results.
    always_comb begin : p_row
        logic [J-1:0] v_h;
        logic [7:0]   v_min;
        v_h   = r_h[r_row_cnt];
        v_min = 8'hFF;
        for (int j = 0; j < J; j++) begin
            if (v_h[j] && (w_rel[j] < v_min)) begin
                v_min = w_rel[j];
            end
        end
        w_syn_next                   = r_syn_acc;
        w_syn_next[r_row_cnt]        = ^(v_h & w_hard);
        w_min_next                   = r_min_acc;
        w_min_next[8*r_row_cnt +: 8] = v_min;
    end

    // Result registers: hard_dec on the first compute edge, the rest on the
    // last one so outputs stay stable until the frame completes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_syn_acc   <= '0;
            r_min_acc   <= '0;
            hard_dec    <= '0;
            syndrome    <= '0;
            row_min_rel <= '0;
            parity_ok   <= 1'b0;
        end else if (state == S_COMPUTE) begin
            r_syn_acc <= w_syn_next;
            r_min_acc <= w_min_next;
            if (r_row_cnt == '0) begin
                hard_dec <= w_hard;
            end
            if (r_row_cnt == RW'(I - 1)) begin
                syndrome    <= w_syn_next;
                row_min_rel <= w_min_next;
                parity_ok   <= ~|w_syn_next;
            end
        end
    end

    assign result_valid = (state == S_DONE);
    assign busy         = (state != S_IDLE);

endmodule

// File: tb/tb_top_fix_case2.sv
// Directed bench for top_fix_case2: hand-computed frames covering the
// nominal codeword, a single-bit error, early tlast, ties, an all-zero
// H row, dropped beats and a reset in the middle of a frame.
module tb_top_fix_case2;

    localparam int J = 14;
    localparam int I = 7;
    localparam int A = 2;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [J-1:0]     H_row;
    logic             H_row_tvalid;
    logic [J*8-1:0]   alpha_u_col;
    logic             alpha_u_col_tvalid;
    logic             alpha_u_col_tlast;
    logic [J-1:0]     hard_dec;
    logic [I-1:0]     syndrome;
    logic             parity_ok;
    logic [I*8-1:0]   row_min_rel;
    logic             result_valid;
    logic             busy;

    int n_checks = 0;
    int n_errors = 0;
    int rv_count = 0;

    top_fix_case2 #(.J(J), .I(I), .A(A)) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .H_row              (H_row),
        .H_row_tvalid       (H_row_tvalid),
        .alpha_u_col        (alpha_u_col),
        .alpha_u_col_tvalid (alpha_u_col_tvalid),
        .alpha_u_col_tlast  (alpha_u_col_tlast),
        .hard_dec           (hard_dec),
        .syndrome           (syndrome),
        .parity_ok          (parity_ok),
        .row_min_rel        (row_min_rel),
        .result_valid       (result_valid),
        .busy               (busy)
    );

    always #5 clk = ~clk;

    // Count result_valid cycles away from the active edge.
    always @(negedge clk) begin
        if (result_valid) rv_count++;
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Advance past the next rising edge; inputs change and outputs are read here.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_h(input logic [J-1:0] row);
        H_row        = row;
        H_row_tvalid = 1'b1;
        step();
        H_row_tvalid = 1'b0;
    endtask

    task automatic send_alpha(input logic [J*8-1:0] col, input logic last);
        alpha_u_col        = col;
        alpha_u_col_tvalid = 1'b1;
        alpha_u_col_tlast  = last;
        step();
        alpha_u_col_tvalid = 1'b0;
        alpha_u_col_tlast  = 1'b0;
    endtask

    // Load one frame and follow it to completion. early: tlast on beat 0.
    // drop_alpha: a stray alpha beat during LOAD_H. drop_h: stray H beats
    // during COMPUTE.
    task automatic run_frame(input string name, input logic [J-1:0] h [I],
                             input logic [J*8-1:0] b0, input logic [J*8-1:0] b1,
                             input logic early, input logic drop_alpha, input logic drop_h);
        int n;
        int rv_before;
        rv_before = rv_count;
        for (int i = 0; i < I; i++) begin
            send_h(h[i]);
            if (i == 0) check({name, " state after H0"}, 128'(dut.state), 128'(3'b001));
            if (drop_alpha && (i == 2)) begin
                send_alpha({J*8{1'b1}}, 1'b1);
                check({name, " state after stray alpha"}, 128'(dut.state), 128'(3'b001));
            end
        end
        check({name, " state after last H"}, 128'(dut.state), 128'(3'b010));
        if (early) begin
            send_alpha(b0, 1'b1);
        end else begin
            send_alpha(b0, 1'b0);
            send_alpha(b1, 1'b1);
        end
        check({name, " state after tlast"}, 128'(dut.state), 128'(3'b011));
        n = 0;
        while (!result_valid && (n < 20)) begin
            if (drop_h && (n < 3)) begin
                H_row        = {J{1'b1}};
                H_row_tvalid = 1'b1;
            end
            step();
            H_row_tvalid = 1'b0;
            n++;
        end
        check({name, " result latency"}, 128'(n), 128'(I));
        check({name, " state DONE"}, 128'(dut.state), 128'(3'b100));
        check({name, " busy in DONE"}, 128'(busy), 128'(1));
        step();
        check({name, " state back to IDLE"}, 128'(dut.state), 128'(3'b000));
        check({name, " result_valid low"}, 128'(result_valid), 128'(0));
        check({name, " busy low"}, 128'(busy), 128'(0));
        check({name, " one result pulse"}, 128'(rv_count - rv_before), 128'(1));
    endtask

    task automatic check_results(input string name, input logic [J-1:0] hd, input logic [I-1:0] syn,
                                 input logic pok, input logic [I*8-1:0] mins);
        check({name, " hard_dec"}, 128'(hard_dec), 128'(hd));
        check({name, " syndrome"}, 128'(syndrome), 128'(syn));
        check({name, " parity_ok"}, 128'(parity_ok), 128'(pok));
        check({name, " row_min_rel"}, 128'(row_min_rel), 128'(mins));
    endtask

    logic [J-1:0]   h_nom  [I];
    logic [J-1:0]   h_zero [I];
    logic [J*8-1:0] b0_nom, b1_nom, b0_err, b1_err, b_eq;

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        h_nom[0] = 14'b01100010100011;
        h_nom[1] = 14'b00110101001010;
        h_nom[2] = 14'b01010011000101;
        h_nom[3] = 14'b10001100001011;
        h_nom[4] = 14'b10001010110100;
        h_nom[5] = 14'b10010100111000;
        h_nom[6] = 14'b01101001010100;
        for (int i = 0; i < I; i++) h_zero[i] = h_nom[i];
        h_zero[3] = '0;
        b0_nom = 112'h74CEB3E7BFCE161B510533F9A6FF;
        b1_nom = 112'h8B324D194132E9E5AEFBCD065A01;
        b0_err = 112'h74CEB3E7BFCE161B510533F9A601;
        b1_err = 112'h8B324D194132E9E5AEFBCD065AFF;
        b_eq   = {J{8'h80}};

        // Reset with beats present on the inputs.
        rst_n              = 1'b0;
        H_row              = {J{1'b1}};
        H_row_tvalid       = 1'b1;
        alpha_u_col        = {J*8{1'b1}};
        alpha_u_col_tvalid = 1'b1;
        alpha_u_col_tlast  = 1'b1;
        repeat (3) step();
        check("reset state", 128'(dut.state), 128'(3'b000));
        check("reset busy", 128'(busy), 128'(0));
        check("reset result_valid", 128'(result_valid), 128'(0));
        check_results("reset", '0, '0, 1'b0, '0);
        H_row_tvalid       = 1'b0;
        alpha_u_col_tvalid = 1'b0;
        alpha_u_col_tlast  = 1'b0;
        rst_n              = 1'b1;
        step();
        check("idle after reset", 128'(dut.state), 128'(3'b000));

        // Nominal codeword.
        run_frame("nominal", h_nom, b0_nom, b1_nom, 1'b0, 1'b0, 1'b0);
        check_results("nominal", 14'b10000011111000, 7'b0000000, 1'b1, 56'h66171717_9C4C4C);

        // Bit 0 flipped: rows 0, 2, 3 violated.
        run_frame("error", h_nom, b0_err, b1_err, 1'b0, 1'b0, 1'b0);
        check_results("error", 14'b10000011111001, 7'b0001101, 1'b0, 56'h66171717_9C4C4C);

        // tlast on beat 0: column 1 reads 0, reliability is beat 0 itself.
        run_frame("early", h_nom, b0_nom, b1_nom, 1'b1, 1'b0, 1'b0);
        check_results("early", 14'b00000000000000, 7'b0000000, 1'b1, 56'h05050533_161B16);

        // Equal alphas everywhere plus an empty H row 3.
        run_frame("ties", h_zero, b_eq, b_eq, 1'b0, 1'b0, 1'b0);
        check_results("ties", 14'b00000000000000, 7'b0000000, 1'b1, 56'h000000FF_000000);

        // Stray beats in states that must ignore them.
        run_frame("dropped", h_nom, b0_nom, b1_nom, 1'b0, 1'b1, 1'b1);
        check_results("dropped", 14'b10000011111000, 7'b0000000, 1'b1, 56'h66171717_9C4C4C);

        // Reset in the middle of COMPUTE.
        begin
            int rv_before;
            for (int i = 0; i < I; i++) send_h(h_nom[i]);
            send_alpha(b0_err, 1'b0);
            send_alpha(b1_err, 1'b1);
            repeat (3) step();
            check("midreset in compute", 128'(dut.state), 128'(3'b011));
            rv_before = rv_count;
            rst_n = 1'b0;
            #2;
            check("midreset state", 128'(dut.state), 128'(3'b000));
            check("midreset busy", 128'(busy), 128'(0));
            check_results("midreset", '0, '0, 1'b0, '0);
            step();
            rst_n = 1'b1;
            repeat (12) step();
            check("midreset no result pulse", 128'(rv_count - rv_before), 128'(0));
            check("midreset idle", 128'(dut.state), 128'(3'b000));
        end
        run_frame("after reset", h_nom, b0_nom, b1_nom, 1'b0, 1'b0, 1'b0);
        check_results("after reset", 14'b10000011111000, 7'b0000000, 1'b1, 56'h66171717_9C4C4C);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
